// File: rtl/decode_if.sv
// decode_if: fetch-to-decode inputs and decode-to-execute D/E register outputs
interface decode_if #(
  parameter int I_WIDTH  = 32,
  parameter int PC_WIDTH = 32,
  parameter int D_WIDTH  = 32
);
  logic [I_WIDTH-1:0]  i_instr;
  logic [PC_WIDTH-1:0] i_pc;
  logic                i_ce;
  logic                i_stall;
  logic                i_flush;
  logic                o_stall;
  logic [4:0]          o_rs1_addr;
  logic [4:0]          o_rs2_addr;
  logic [4:0]          o_rs1_addr_q;
  logic [4:0]          o_rs2_addr_q;
  logic [4:0]          o_rd_addr;
  logic [D_WIDTH-1:0]  o_imm;
  logic [2:0]          o_funct3;
  logic [6:0]          o_opcode;
  logic [3:0]          o_alu_op;
  logic [PC_WIDTH-1:0] o_pc;
  logic                o_illegal;
  logic                o_ce;

  modport slave (
    input  i_instr, i_pc, i_ce, i_stall, i_flush,
    output o_stall, o_rs1_addr, o_rs2_addr, o_rs1_addr_q, o_rs2_addr_q, o_rd_addr,
           o_imm, o_funct3, o_opcode, o_alu_op, o_pc, o_illegal, o_ce
  );

  modport master (
    output i_instr, i_pc, i_ce, i_stall, i_flush,
    input  o_stall, o_rs1_addr, o_rs2_addr, o_rs1_addr_q, o_rs2_addr_q, o_rd_addr,
           o_imm, o_funct3, o_opcode, o_alu_op, o_pc, o_illegal, o_ce
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode into a registered D/E pipeline register
module decode_stage #(
  parameter int I_WIDTH  = 32,
  parameter int PC_WIDTH = 32,
  parameter int D_WIDTH  = 32
) (
  input logic     d_clk,
  input logic     d_rst,
  decode_if.slave bus
);
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  logic [I_WIDTH-1:0]  ins;
  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic [6:0]          funct7;
  logic                is_load, is_imm, is_store, is_reg, is_branch;
  logic                is_i, is_u;
  logic                bad_op, bad_reg, bad_shift, bad_branch, bad_load, bad_store;
  logic                illegal;
  logic [31:0]         imm32;
  logic [D_WIDTH-1:0]  imm;
  logic [3:0]          fn_op;
  logic [3:0]          alu_op;

  logic [4:0]          rs1_q, rs2_q, rd_q;
  logic [D_WIDTH-1:0]  imm_q;
  logic [2:0]          funct3_q;
  logic [6:0]          opcode_q;
  logic [3:0]          alu_op_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic                illegal_q;
  logic                ce_q;

  assign ins    = bus.i_instr;
  assign opcode = ins[6:0];
  assign funct3 = ins[14:12];
  assign funct7 = ins[31:25];

  assign is_load   = opcode == OP_LOAD;
  assign is_imm    = opcode == OP_IMM;
  assign is_store  = opcode == OP_STORE;
  assign is_reg    = opcode == OP_REG;
  assign is_branch = opcode == OP_BRANCH;
  assign is_i      = is_load || is_imm || opcode == OP_JALR || opcode == OP_SYSTEM;
  assign is_u      = opcode == OP_LUI || opcode == OP_AUIPC;

  assign bad_op = !(is_load || is_imm || is_store || is_reg || is_branch || is_u ||
                    opcode == OP_JALR || opcode == OP_JAL || opcode == OP_SYSTEM);
  assign bad_reg = is_reg && !(funct7 == 7'b0000000 ||
                               (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
  assign bad_shift = is_imm && ((funct3 == 3'b001 && funct7 != 7'b0000000) ||
                                (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000));
  assign bad_branch = is_branch && (funct3 == 3'b010 || funct3 == 3'b011);
  assign bad_load   = is_load && (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
  assign bad_store  = is_store && funct3 >= 3'b011;
  assign illegal    = bad_op || bad_reg || bad_shift || bad_branch || bad_load || bad_store;

  // Every format sign-extends from bit 31; B and J drop bit 0, U zeros the low 12
  always_comb begin
    imm32 = is_i      ? {{20{ins[31]}}, ins[31:20]} :
            is_store  ? {{20{ins[31]}}, ins[31:25], ins[11:7]} :
            is_branch ? {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0} :
            is_u      ? {ins[31:12], 12'b0} :
            opcode == OP_JAL ? {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0} :
            32'd0;
    imm = D_WIDTH'(signed'(imm32));
  end

  // funct7[5] only picks SUB for register ops; ADDI ignores it, SRAI honours it
  always_comb begin
    fn_op = funct3 == 3'b000 ? ((is_reg && funct7[5]) ? ALU_SUB : ALU_ADD) :
            funct3 == 3'b001 ? ALU_SLL :
            funct3 == 3'b010 ? ALU_SLT :
            funct3 == 3'b011 ? ALU_SLTU :
            funct3 == 3'b100 ? ALU_XOR :
            funct3 == 3'b101 ? (funct7[5] ? ALU_SRA : ALU_SRL) :
            funct3 == 3'b110 ? ALU_OR : ALU_AND;
    alu_op = illegal               ? ALU_ADD :
             (is_reg || is_imm)    ? fn_op :
             is_branch             ? ALU_SUB : ALU_ADD;
  end

  always_ff @(posedge d_clk) begin
    if (d_rst || bus.i_flush) begin
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      funct3_q  <= '0;
      opcode_q  <= '0;
      alu_op_q  <= '0;
      pc_q      <= '0;
      illegal_q <= 1'b0;
      ce_q      <= 1'b0;
    end else if (!bus.i_stall) begin
      ce_q      <= bus.i_ce;
      illegal_q <= bus.i_ce && illegal;
      if (bus.i_ce) begin
        rs1_q    <= ins[19:15];
        rs2_q    <= ins[24:20];
        rd_q     <= ins[11:7];
        imm_q    <= imm;
        funct3_q <= funct3;
        opcode_q <= opcode;
        alu_op_q <= alu_op;
        pc_q     <= bus.i_pc;
      end
    end
  end

  assign bus.o_stall      = bus.i_stall;
  assign bus.o_rs1_addr   = ins[19:15];
  assign bus.o_rs2_addr   = ins[24:20];
  assign bus.o_rs1_addr_q = rs1_q;
  assign bus.o_rs2_addr_q = rs2_q;
  assign bus.o_rd_addr    = rd_q;
  assign bus.o_imm        = imm_q;
  assign bus.o_funct3     = funct3_q;
  assign bus.o_opcode     = opcode_q;
  assign bus.o_alu_op     = alu_op_q;
  assign bus.o_pc         = pc_q;
  assign bus.o_illegal    = illegal_q;
  assign bus.o_ce         = ce_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed-vector bench for decode_stage
module tb_decode_stage;
  logic d_clk = 1'b0;
  logic d_rst = 1'b1;
  int   vectors = 0;
  int   errs    = 0;

  decode_if bus ();
  decode_stage dut (.d_clk(d_clk), .d_rst(d_rst), .bus(bus));

  always #5 d_clk = ~d_clk;

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic ce, input logic stall, input logic flush);
    bus.i_instr = instr;
    bus.i_pc    = pc;
    bus.i_ce    = ce;
    bus.i_stall = stall;
    bus.i_flush = flush;
    @(posedge d_clk);
    #1;
  endtask

  task automatic test_reset;
    d_rst = 1'b1;
    drive(32'h00500093, 32'h10, 1'b1, 1'b0, 1'b0);
    drive(32'h00500093, 32'h10, 1'b1, 1'b0, 1'b0);
    vectors++;
    if ({bus.o_ce, bus.o_illegal, bus.o_rd_addr, bus.o_imm, bus.o_alu_op, bus.o_opcode, bus.o_pc} !== '0) begin
      errs++;
      $display("FAIL reset: ce=%b ill=%b rd=%0d imm=%h alu=%0d op=%h pc=%h want all 0",
               bus.o_ce, bus.o_illegal, bus.o_rd_addr, bus.o_imm, bus.o_alu_op, bus.o_opcode, bus.o_pc);
    end
    d_rst = 1'b0;
  endtask

  task automatic test_addi;
    drive(32'h00500093, 32'h0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if ({bus.o_ce, bus.o_rd_addr, bus.o_rs1_addr_q, bus.o_imm, bus.o_alu_op, bus.o_opcode, bus.o_illegal}
        !== {1'b1, 5'd1, 5'd0, 32'h5, 4'd0, 7'h13, 1'b0}) begin
      errs++;
      $display("FAIL addi: ce=%b rd=%0d rs1q=%0d imm=%h alu=%0d op=%h ill=%b want 1/1/0/00000005/0/13/0",
               bus.o_ce, bus.o_rd_addr, bus.o_rs1_addr_q, bus.o_imm, bus.o_alu_op, bus.o_opcode, bus.o_illegal);
    end
  endtask

  task automatic test_sub;
    drive(32'h402081B3, 32'h4, 1'b1, 1'b0, 1'b0);
    vectors++;
    if ({bus.o_ce, bus.o_alu_op, bus.o_rd_addr, bus.o_rs1_addr_q, bus.o_rs2_addr_q, bus.o_imm, bus.o_pc}
        !== {1'b1, 4'd1, 5'd3, 5'd1, 5'd2, 32'h0, 32'h4}) begin
      errs++;
      $display("FAIL sub: ce=%b alu=%0d rd=%0d rs1q=%0d rs2q=%0d imm=%h pc=%h want 1/1/3/1/2/0/4",
               bus.o_ce, bus.o_alu_op, bus.o_rd_addr, bus.o_rs1_addr_q, bus.o_rs2_addr_q, bus.o_imm, bus.o_pc);
    end
  endtask

  task automatic test_comb_addr;
    bus.i_instr = 32'h402081B3;
    #1;
    vectors++;
    if ({bus.o_rs1_addr, bus.o_rs2_addr} !== {5'd1, 5'd2}) begin
      errs++;
      $display("FAIL comb_addr: rs1=%0d rs2=%0d want 1/2", bus.o_rs1_addr, bus.o_rs2_addr);
    end
  endtask

  task automatic test_branch_lui;
    drive(32'hFE208EE3, 32'h8, 1'b1, 1'b0, 1'b0);
    vectors++;
    if ({bus.o_imm, bus.o_alu_op, bus.o_illegal} !== {32'hFFFFFFFC, 4'd1, 1'b0}) begin
      errs++;
      $display("FAIL beq: imm=%h alu=%0d ill=%b want fffffffc/1/0", bus.o_imm, bus.o_alu_op, bus.o_illegal);
    end
    drive(32'h123452B7, 32'hC, 1'b1, 1'b0, 1'b0);
    vectors++;
    if ({bus.o_imm, bus.o_rd_addr, bus.o_alu_op} !== {32'h12345000, 5'd5, 4'd0}) begin
      errs++;
      $display("FAIL lui: imm=%h rd=%0d alu=%0d want 12345000/5/0", bus.o_imm, bus.o_rd_addr, bus.o_alu_op);
    end
  endtask

  task automatic test_formats;
    drive(32'h0020A423, 32'h10, 1'b1, 1'b0, 1'b0);
    vectors++;
    if ({bus.o_imm, bus.o_funct3, bus.o_illegal} !== {32'h8, 3'd2, 1'b0}) begin
      errs++;
      $display("FAIL sw: imm=%h f3=%0d ill=%b want 00000008/2/0", bus.o_imm, bus.o_funct3, bus.o_illegal);
    end
    drive(32'hFF9FF0EF, 32'h14, 1'b1, 1'b0, 1'b0);
    vectors++;
    if ({bus.o_imm, bus.o_rd_addr, bus.o_alu_op} !== {32'hFFFFFFF8, 5'd1, 4'd0}) begin
      errs++;
      $display("FAIL jal: imm=%h rd=%0d alu=%0d want fffffff8/1/0", bus.o_imm, bus.o_rd_addr, bus.o_alu_op);
    end
    drive(32'h4030D093, 32'h18, 1'b1, 1'b0, 1'b0);
    vectors++;
    if ({bus.o_alu_op, bus.o_imm, bus.o_illegal} !== {4'd7, 32'h403, 1'b0}) begin
      errs++;
      $display("FAIL srai: alu=%0d imm=%h ill=%b want 7/00000403/0", bus.o_alu_op, bus.o_imm, bus.o_illegal);
    end
  endtask

  task automatic test_stall;
    drive(32'h00500093, 32'h20, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      bus.i_instr = 32'h402081B3;
      bus.i_pc    = 32'h24;
      bus.i_stall = 1'b1;
      #1;
      vectors++;
      if (bus.o_stall !== 1'b1) begin
        errs++;
        $display("FAIL stall_out[%0d]: o_stall=%b want 1", k, bus.o_stall);
      end
      drive(32'h402081B3, 32'h24, 1'b1, 1'b1, 1'b0);
      vectors++;
      if ({bus.o_ce, bus.o_rd_addr, bus.o_alu_op, bus.o_imm, bus.o_pc} !== {1'b1, 5'd1, 4'd0, 32'h5, 32'h20}) begin
        errs++;
        $display("FAIL stall_hold[%0d]: ce=%b rd=%0d alu=%0d imm=%h pc=%h want 1/1/0/00000005/20",
                 k, bus.o_ce, bus.o_rd_addr, bus.o_alu_op, bus.o_imm, bus.o_pc);
      end
    end
    drive(32'h402081B3, 32'h24, 1'b1, 1'b0, 1'b0);
    vectors++;
    if ({bus.o_stall, bus.o_ce, bus.o_rd_addr, bus.o_alu_op, bus.o_pc} !== {1'b0, 1'b1, 5'd3, 4'd1, 32'h24}) begin
      errs++;
      $display("FAIL stall_release: stall=%b ce=%b rd=%0d alu=%0d pc=%h want 0/1/3/1/24",
               bus.o_stall, bus.o_ce, bus.o_rd_addr, bus.o_alu_op, bus.o_pc);
    end
  endtask

  task automatic test_flush;
    drive(32'hFFFFFFFF, 32'h28, 1'b1, 1'b0, 1'b0);
    drive(32'h00500093, 32'h2C, 1'b1, 1'b1, 1'b1);
    vectors++;
    if ({bus.o_ce, bus.o_illegal} !== 2'b00) begin
      errs++;
      $display("FAIL flush: ce=%b ill=%b want 0/0", bus.o_ce, bus.o_illegal);
    end
    drive(32'h00500093, 32'h30, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (bus.o_ce !== 1'b0) begin
      errs++;
      $display("FAIL idle: ce=%b want 0", bus.o_ce);
    end
  endtask

  task automatic test_midreset;
    drive(32'h402081B3, 32'h34, 1'b1, 1'b0, 1'b0);
    d_rst = 1'b1;
    drive(32'h123452B7, 32'h38, 1'b1, 1'b1, 1'b1);
    d_rst = 1'b0;
    vectors++;
    if ({bus.o_ce, bus.o_illegal, bus.o_rd_addr, bus.o_rs1_addr_q, bus.o_rs2_addr_q, bus.o_imm,
         bus.o_funct3, bus.o_alu_op, bus.o_opcode, bus.o_pc} !== '0) begin
      errs++;
      $display("FAIL midreset: ce=%b ill=%b rd=%0d imm=%h alu=%0d op=%h pc=%h want all 0",
               bus.o_ce, bus.o_illegal, bus.o_rd_addr, bus.o_imm, bus.o_alu_op, bus.o_opcode, bus.o_pc);
    end
  endtask

  task automatic test_illegal;
    logic [31:0] bad [5] = '{32'hFFFFFFFF, 32'h00003003, 32'h6030D093, 32'h40309093, 32'hFE20AEE3};
    for (int k = 0; k < 5; k++) begin
      drive(bad[k], 32'h40, 1'b1, 1'b0, 1'b0);
      vectors++;
      if ({bus.o_illegal, bus.o_ce, bus.o_alu_op} !== {1'b1, 1'b1, 4'd0}) begin
        errs++;
        $display("FAIL illegal[%h]: ill=%b ce=%b alu=%0d want 1/1/0", bad[k], bus.o_illegal, bus.o_ce, bus.o_alu_op);
      end
    end
    drive(32'h00000073, 32'h44, 1'b1, 1'b0, 1'b0);
    vectors++;
    if ({bus.o_illegal, bus.o_ce, bus.o_opcode} !== {1'b0, 1'b1, 7'h73}) begin
      errs++;
      $display("FAIL system: ill=%b ce=%b op=%h want 0/1/73", bus.o_illegal, bus.o_ce, bus.o_opcode);
    end
  endtask

  initial begin
    test_reset;
    test_addi;
    test_comb_addr;
    test_sub;
    test_branch_lui;
    test_formats;
    test_stall;
    test_flush;
    test_midreset;
    test_illegal;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
